tx_burst_core: RTL



---
 rtl/tx_burst_core.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/tx_burst_core.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tx_burst_core
// Brief    : FIFO-buffered DAC burst framer: preamble, gain-scaled payload, guard.
// Revision : 1.0
// ============================================================================
module tx_burst_core #(
    parameter int NUMBER_OF_LINE = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int PREAMBLE_WORDS = 4,
    parameter int GUARD_WORDS    = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [16*NUMBER_OF_LINE-1:0]  s_data,
    input  logic                          s_valid,
    input  logic                          s_last,
    output logic                          s_ready,
    input  logic                          start,
    input  logic [7:0]                    gain,
    output logic [16*NUMBER_OF_LINE-1:0]  dac_data,
    output logic                          dac_active,
    output logic                          busy,
    output logic                          underrun
);

    localparam int c_W    = 16 * NUMBER_OF_LINE;
    localparam int c_AW   = $clog2(FIFO_DEPTH);
    localparam int c_CMAX = (PREAMBLE_WORDS > GUARD_WORDS) ? PREAMBLE_WORDS : GUARD_WORDS;
    localparam int c_CW   = $clog2(c_CMAX) + 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_PAYLOAD  = 2'd2,
        S_GUARD    = 2'd3
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [c_W-1:0]    r_dac;
    logic              r_active;
    logic              r_underrun;

    logic [c_W:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;

    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic [c_W:0]      w_head;
    logic [c_W-1:0]    w_scaled;
    logic [c_W-1:0]    w_pre;

    assign w_ready = (r_count != (c_AW+1)'(FIFO_DEPTH));
    assign w_push  = s_valid && w_ready;
    assign w_pop   = (r_state == S_PAYLOAD) && (r_count != '0);
    assign w_head  = r_mem[r_rd_ptr];

    // Per-lane 16s x 8u product, floor-divided by 128, then clamped to int16.
    generate
        for (genvar k = 0; k < NUMBER_OF_LINE; k++) begin : g_lane
            logic signed [24:0] w_prod;
            logic signed [17:0] w_shr;
            assign w_prod = $signed(w_head[16*k +: 16]) * $signed({1'b0, gain});
            assign w_shr  = 18'(w_prod >>> 7);
            assign w_scaled[16*k +: 16] = (w_shr > 18'sd32767)  ? 16'h7FFF :
                                          (w_shr < -18'sd32768) ? 16'h8000 :
                                          w_shr[15:0];
            assign w_pre[16*k +: 16] = ((k % 2) == 0) ? 16'h4000 : 16'hC000;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_last, s_data};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (c_AW+1)'(w_push) - (c_AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_dac      <= '0;
            r_active   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_dac    <= '0;
            r_active <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_PREAMBLE;
                        r_cnt      <= '0;
                        r_underrun <= 1'b0;
                    end
                end
                S_PREAMBLE: begin
                    r_dac    <= w_pre;
                    r_active <= 1'b1;
                    if (r_cnt == c_CW'(PREAMBLE_WORDS - 1)) begin
                        r_state <= S_PAYLOAD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PAYLOAD: begin
                    if (w_pop) begin
                        r_dac    <= w_scaled;
                        r_active <= 1'b1;
                        if (w_head[c_W]) begin
                            r_state <= S_GUARD;
                            r_cnt   <= '0;
                        end
                    end else begin
                        r_underrun <= 1'b1;
                    end
                end
                S_GUARD: begin
                    if (r_cnt == c_CW'(GUARD_WORDS - 1)) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s_ready    = w_ready;
    assign dac_data   = r_dac;
    assign dac_active = r_active;
    assign busy       = (r_state != S_IDLE);
    assign underrun   = r_underrun;

endmodule
`default_nettype wire
